// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit (mdu_iter).
package mdu_pkg;

   localparam logic [1:0] MDU_MULT  = 2'b00;
   localparam logic [1:0] MDU_MULTU = 2'b01;
   localparam logic [1:0] MDU_DIV   = 2'b10;
   localparam logic [1:0] MDU_DIVU  = 2'b11;

   // Every quotient bit is set when the divisor is zero.
   localparam logic MDU_DIV0_QUO_BIT = 1'b1;

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} mdu_state_e;

   function automatic logic op_is_div(input logic [1:0] op);
      return op[1];
   endfunction

   function automatic logic op_is_signed(input logic [1:0] op);
      return ~op[0];
   endfunction

endpackage

// File: rtl/mdu_absneg.sv
// Conditional two's-complement negate; used for operand magnitudes and result sign fix-up.
module mdu_absneg #(
   parameter int W = 32
) (
   input  logic [W-1:0] val,
   input  logic         neg,
   output logic [W-1:0] res
);

   assign res = neg ? (~val + W'(1)) : val;

endmodule

// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply / restoring divide into private HI/LO registers.
// Optional build macro MDU_EARLY_OUT_EN shortens multiplies once the multiplier bits run out.
module mdu_iter
   import mdu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CNT_W  = $clog2(DATA_W) + 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [1:0]        op_i,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   input  logic              flush_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [DATA_W-1:0] hi_o,
   output logic [DATA_W-1:0] lo_o
);

   localparam int              PW       = 2 * DATA_W;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DATA_W);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   mdu_state_e        state, state_nx;
   logic [1:0]        op_q;
   logic              neg_res, neg_rem, div0;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] dvs, hi_w, lo_w, hi_nx, lo_nx, hi_q, lo_q;
   logic [DATA_W-1:0] a_mag, b_mag, quo_fix, rem_fix;
   logic [PW-1:0]     prod_fix;
   logic [DATA_W:0]   mul_sum, rem_sh, trial;
   logic              sgn_in, start_ok, early;

   assign sgn_in   = op_is_signed(op_i);
   assign start_ok = start_i & ~flush_i & ((state == IDLE) | (state == DONE));

   mdu_absneg #(.W(DATA_W)) u_abs_a (.val(a_i), .neg(sgn_in & a_i[DATA_W-1]), .res(a_mag));
   mdu_absneg #(.W(DATA_W)) u_abs_b (.val(b_i), .neg(sgn_in & b_i[DATA_W-1]), .res(b_mag));
   mdu_absneg #(.W(PW))     u_fix_prod (.val({hi_w, lo_w}), .neg(neg_res), .res(prod_fix));
   mdu_absneg #(.W(DATA_W)) u_fix_quo  (.val(lo_w), .neg(neg_res), .res(quo_fix));
   mdu_absneg #(.W(DATA_W)) u_fix_rem  (.val(hi_w), .neg(neg_rem), .res(rem_fix));

`ifdef MDU_EARLY_OUT_EN
   // The low cnt bits of lo_w are the multiplier bits not yet consumed.
   logic [DATA_W-1:0] live_mask;
   assign live_mask = ~({DATA_W{1'b1}} << cnt);
   assign early     = ~op_is_div(op_q) & ((lo_w & live_mask) == '0);
`else
   assign early = 1'b0;
`endif

   // One iteration: shift-add for multiply, shift-subtract-restore for divide.
   always_comb begin
      mul_sum = {1'b0, hi_w} + (lo_w[0] ? {1'b0, dvs} : '0);
      rem_sh  = {hi_w, lo_w[DATA_W-1]};
      trial   = rem_sh - {1'b0, dvs};
      hi_nx   = hi_w;
      lo_nx   = lo_w;
      if (early) begin
         {hi_nx, lo_nx} = {hi_w, lo_w} >> cnt;
      end else if (op_is_div(op_q)) begin
         if (!trial[DATA_W]) begin
            hi_nx = trial[DATA_W-1:0];
            lo_nx = {lo_w[DATA_W-2:0], 1'b1};
         end else begin
            hi_nx = rem_sh[DATA_W-1:0];
            lo_nx = {lo_w[DATA_W-2:0], 1'b0};
         end
      end else begin
         hi_nx = mul_sum[DATA_W:1];
         lo_nx = {mul_sum[0], lo_w[DATA_W-1:1]};
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE, DONE: state_nx = start_ok ? CALC : IDLE;
         CALC: begin
            if (flush_i)                       state_nx = IDLE;
            else if ((cnt == CNT_ONE) || early) state_nx = FIX;
         end
         FIX:     state_nx = flush_i ? IDLE : DONE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         op_q    <= '0;
         neg_res <= 1'b0;
         neg_rem <= 1'b0;
         div0    <= 1'b0;
         cnt     <= '0;
         dvs     <= '0;
         hi_w    <= '0;
         lo_w    <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else if (start_ok) begin
         op_q    <= op_i;
         neg_res <= sgn_in & (a_i[DATA_W-1] ^ b_i[DATA_W-1]);
         neg_rem <= sgn_in & a_i[DATA_W-1];
         div0    <= (b_i == '0);
         cnt     <= CNT_INIT;
         hi_w    <= '0;
         // dvs holds the addend/subtrahend; lo_w holds the bits consumed one per cycle.
         if (op_is_div(op_i)) begin
            dvs  <= b_mag;
            lo_w <= a_mag;
         end else begin
            dvs  <= a_mag;
            lo_w <= b_mag;
         end
      end else if ((state == CALC) && !flush_i) begin
         hi_w <= hi_nx;
         lo_w <= lo_nx;
         cnt  <= cnt - CNT_ONE;
      end else if ((state == FIX) && !flush_i) begin
         if (op_is_div(op_q)) begin
            lo_q <= div0 ? {DATA_W{MDU_DIV0_QUO_BIT}} : quo_fix;
            hi_q <= rem_fix;
         end else begin
            {hi_q, lo_q} <= prod_fix;
         end
      end
   end

   assign busy_o = (state == CALC) | (state == FIX);
   assign done_o = (state == DONE);
   assign hi_o   = hi_q;
   assign lo_o   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed and randomized checks of mdu_iter (DATA_W=32) against an arithmetic reference model.
module tb_mdu_iter;
   import mdu_pkg::*;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         start_i, flush_i;
   logic [1:0]   op_i;
   logic [W-1:0] a_i, b_i;
   logic         busy_o, done_o;
   logic [W-1:0] hi_o, lo_o;

   int tests = 0;
   int fails = 0;
   logic [W-1:0] exp_hi, exp_lo;

   always #5 clk = ~clk;

   mdu_iter #(.DATA_W(W)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
      .flush_i(flush_i), .busy_o(busy_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: plain arithmetic on the architectural meaning of each op.
   function automatic void model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] hi, output logic [W-1:0] lo);
      logic [63:0] p;
      longint      sp;
      int          q, r;
      hi = '0;
      lo = '0;
      case (op)
         MDU_MULT: begin
            sp = longint'($signed(a)) * longint'($signed(b));
            p  = sp;
            hi = p[63:32];
            lo = p[31:0];
         end
         MDU_MULTU: begin
            p  = {32'b0, a} * {32'b0, b};
            hi = p[63:32];
            lo = p[31:0];
         end
         MDU_DIV: begin
            if (b == 0) begin
               lo = '1; hi = a;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               lo = 32'h8000_0000; hi = '0;
            end else begin
               q = $signed(a) / $signed(b);
               r = $signed(a) % $signed(b);
               lo = q; hi = r;
            end
         end
         default: begin
            if (b == 0) begin
               lo = '1; hi = a;
            end else begin
               lo = a / b; hi = a % b;
            end
         end
      endcase
   endfunction

   task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      op_i = op; a_i = a; b_i = b; start_i = 1'b1;
      @(posedge clk);
      #1 start_i = 1'b0;
   endtask

   // Counts cycles after the start edge until done_o; optionally pulses a stray start mid-run.
   task automatic wait_done(input int inject_at, output int lat, output int busy_n);
      lat = 0;
      busy_n = 0;
      @(negedge clk);
      while (!done_o && lat < 200) begin
         if (busy_o) busy_n++;
         start_i = (lat == inject_at);
         if (lat == inject_at) begin
            op_i = 2'($urandom_range(0, 3));
            a_i  = $urandom;
            b_i  = $urandom;
         end
         @(negedge clk);
         lat++;
      end
      start_i = 1'b0;
   endtask

   task automatic run_check(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                            input logic [W-1:0] b, input int inject_at);
      int lat, busy_n;
      issue(op, a, b);
      wait_done(inject_at, lat, busy_n);
      model(op, a, b, exp_hi, exp_lo);
      chk({tag, "_lat"}, 64'(lat), 64'(W + 1));
      chk({tag, "_hi"}, 64'(hi_o), 64'(exp_hi));
      chk({tag, "_lo"}, 64'(lo_o), 64'(exp_lo));
   endtask

   initial begin
      int lat, busy_n;
      logic [1:0]   rop;
      logic [W-1:0] ra, rb;

      rst = 1'b1; start_i = 1'b0; flush_i = 1'b0; op_i = '0; a_i = '0; b_i = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", 64'(busy_o), 64'(0));
      chk("rst_done", 64'(done_o), 64'(0));
      chk("rst_hi", 64'(hi_o), 64'(0));
      chk("rst_lo", 64'(lo_o), 64'(0));
      rst = 1'b0;

      // Full-scale unsigned multiply, latency and busy window.
      issue(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done(-1, lat, busy_n);
      chk("multu_lat", 64'(lat), 64'(33));
      chk("multu_busy", 64'(busy_n), 64'(33));
      chk("multu_hi", 64'(hi_o), 64'h0000_0000_FFFF_FFFE);
      chk("multu_lo", 64'(lo_o), 64'h0000_0000_0000_0001);
      @(negedge clk);
      chk("done_pulse", 64'(done_o), 64'(0));
      chk("idle_busy", 64'(busy_o), 64'(0));

      run_check("mult_neg", MDU_MULT, 32'hFFFF_FFF9, 32'd6, -1);
      chk("mult_neg_const_lo", 64'(lo_o), 64'h0000_0000_FFFF_FFD6);
      run_check("div_neg", MDU_DIV, 32'hFFFF_FFF9, 32'd2, -1);
      chk("div_neg_const_lo", 64'(lo_o), 64'h0000_0000_FFFF_FFFD);
      run_check("divu_zero", MDU_DIVU, 32'd100, 32'd0, -1);
      run_check("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1);

      // Flush with a simultaneous start at cycle 10.
      issue(MDU_DIVU, 32'd100, 32'd7);
      @(negedge clk);
      repeat (10) @(negedge clk);
      flush_i = 1'b1; start_i = 1'b1;
      @(negedge clk);
      flush_i = 1'b0; start_i = 1'b0;
      chk("flush_busy", 64'(busy_o), 64'(0));
      chk("flush_done", 64'(done_o), 64'(0));
      chk("flush_hi", 64'(hi_o), 64'(exp_hi));
      chk("flush_lo", 64'(lo_o), 64'(exp_lo));
      @(negedge clk);
      chk("flush_done_later", 64'(done_o), 64'(0));
      run_check("after_flush", MDU_DIVU, 32'd100, 32'd7, -1);
      chk("after_flush_lo", 64'(lo_o), 64'(14));

      // Back-to-back: start held through DONE.
      run_check("b2b_first", MDU_MULTU, 32'd1234, 32'd5678, -1);
      op_i = MDU_DIV; a_i = 32'hFFFF_0000; b_i = 32'd3; start_i = 1'b1;
      @(posedge clk);
      #1 start_i = 1'b0;
      wait_done(-1, lat, busy_n);
      model(MDU_DIV, 32'hFFFF_0000, 32'd3, exp_hi, exp_lo);
      chk("b2b_lat", 64'(lat), 64'(33));
      chk("b2b_hi", 64'(hi_o), 64'(exp_hi));
      chk("b2b_lo", 64'(lo_o), 64'(exp_lo));

      // A stray start pulse mid-CALC must not disturb the running op.
      run_check("ignore_start", MDU_MULT, 32'h8000_0000, 32'h7FFF_FFFF, 5);

      // Reset mid-CALC clears outputs asynchronously.
      issue(MDU_DIVU, 32'hDEAD_BEEF, 32'd13);
      repeat (8) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mid_rst_busy", 64'(busy_o), 64'(0));
      chk("mid_rst_done", 64'(done_o), 64'(0));
      chk("mid_rst_hi", 64'(hi_o), 64'(0));
      chk("mid_rst_lo", 64'(lo_o), 64'(0));
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 30; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = $urandom;
         case ($urandom_range(0, 4))
            0: rb = 32'($urandom_range(0, 15));
            1: rb = '0;
            2: ra = 32'h8000_0000;
            3: rb = -32'($urandom_range(1, 9));
            default: ;
         endcase
         run_check($sformatf("rand%0d", i), rop, ra, rb, -1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
